// File: rtl/instruction_memory_pipelined.sv
// Pipelined instruction store: request/valid fetch port with 1- or 2-cycle read latency,
// fault fill on misaligned/out-of-range fetches, and a streaming program-load port.
module instruction_memory_pipelined #(
  parameter int          ADDR_WIDTH   = 64,
  parameter int          DEPTH_WORDS  = 64,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] FAULT_DATA   = 32'hD503201F,
  parameter string       INIT_FILE    = ""
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  FetchReq,
  input  logic [ADDR_WIDTH-1:0] Address,
  output logic                  FetchReady,
  output logic                  FetchValid,
  output logic [31:0]           Data,
  output logic                  Fault,
  input  logic                  Hold,
  input  logic                  LoadStart,
  input  logic [ADDR_WIDTH-1:0] LoadBase,
  input  logic                  LoadValid,
  input  logic [31:0]           LoadData,
  input  logic                  LoadLast,
  output logic                  LoadBusy,
  output logic                  LoadError
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = ADDR_WIDTH - 2;

  typedef struct packed {
    logic        fault;
    logic [31:0] data;
  } resp_t;

  typedef enum logic [1:0] {RUN, LOAD, DRAIN} state_t;

  state_t             state;
  logic [PTR_W-1:0]   wptr;
  logic [1:0]         drain_cnt;
  logic               wptr_ok;
  logic               mem_we;

  logic [IDX_W-1:0]   f_idx;
  logic               f_fault;
  logic               acc;

  logic [READ_LATENCY:1] vld_pipe;
  resp_t                 out_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Array contents survive reset; the array starts all zero.
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end

  always @(posedge CLK) begin
    if (mem_we) mem[wptr[IDX_W-1:0]] <= LoadData;
  end

  // Fetch decode
  assign f_idx      = Address[IDX_W+1:2];
  assign f_fault    = (Address[1:0] != 2'b00) || (|Address[ADDR_WIDTH-1:IDX_W+2]);
  assign FetchReady = (state == RUN) && !Hold && !LoadStart;
  assign acc        = FetchReq && FetchReady;

  // Load sequencer
  assign wptr_ok = (wptr < PTR_W'(DEPTH_WORDS));
  assign mem_we  = (state == LOAD) && LoadValid && wptr_ok;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= RUN;
      wptr      <= '0;
      drain_cnt <= '0;
      LoadBusy  <= 1'b0;
      LoadError <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (LoadStart) begin
            state     <= LOAD;
            LoadBusy  <= 1'b1;
            wptr      <= LoadBase[ADDR_WIDTH-1:2];
            LoadError <= (LoadBase[1:0] != 2'b00);
          end
        end
        LOAD: begin
          if (LoadValid) begin
            // pointer parks past the end instead of wrapping; later beats are dropped
            if (!wptr_ok) LoadError <= 1'b1;
            else          wptr      <= wptr + 1'b1;
            if (LoadLast) begin
              state     <= DRAIN;
              drain_cnt <= 2'(READ_LATENCY - 1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd0) begin
            state    <= RUN;
            LoadBusy <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        default: begin
          state    <= RUN;
          LoadBusy <= 1'b0;
        end
      endcase
    end
  end

  // Read pipeline; Hold freezes every stage including the outputs
  if (READ_LATENCY == 1) begin : g_rl1
    always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
        vld_pipe <= '0;
        out_q    <= '0;
      end else if (!Hold) begin
        vld_pipe[1] <= acc;
        if (acc) begin
          out_q.fault <= f_fault;
          out_q.data  <= f_fault ? FAULT_DATA : mem[f_idx];
        end
      end
    end
  end else begin : g_rl2
    logic [31:0] rd_q;
    logic        flt_q;

    always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
        vld_pipe <= '0;
        rd_q     <= '0;
        flt_q    <= 1'b0;
        out_q    <= '0;
      end else if (!Hold) begin
        vld_pipe <= {vld_pipe[1], acc};
        if (acc) begin
          flt_q <= f_fault;
          if (!f_fault) rd_q <= mem[f_idx];
        end
        if (vld_pipe[1]) begin
          out_q.fault <= flt_q;
          out_q.data  <= flt_q ? FAULT_DATA : rd_q;
        end
      end
    end
  end

  assign FetchValid = vld_pipe[READ_LATENCY];
  assign Data       = out_q.data;
  assign Fault      = out_q.fault;

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// Scoreboard bench: one instance per read latency, shared stimulus, queued expectations
// checked by a negedge monitor (data, fault and the cycle each response is consumed).
module tb_instruction_memory_pipelined;

  localparam logic [31:0] FD = 32'hD503201F;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        FetchReq, Hold, LoadStart, LoadValid, LoadLast;
  logic [63:0] Address, LoadBase;
  logic [31:0] LoadData;

  logic [1:0]  rdy, fv, flt, busy, lerr;
  logic [31:0] dat [2];

  int tests = 0;
  int fails = 0;
  int act   = 0;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 CLK = ~CLK;

  instruction_memory_pipelined #(.READ_LATENCY(1)) u_dut1 (
    .CLK(CLK), .Reset(Reset), .FetchReq(FetchReq), .Address(Address),
    .FetchReady(rdy[0]), .FetchValid(fv[0]), .Data(dat[0]), .Fault(flt[0]),
    .Hold(Hold), .LoadStart(LoadStart), .LoadBase(LoadBase), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadLast(LoadLast), .LoadBusy(busy[0]), .LoadError(lerr[0])
  );

  instruction_memory_pipelined #(.READ_LATENCY(2)) u_dut2 (
    .CLK(CLK), .Reset(Reset), .FetchReq(FetchReq), .Address(Address),
    .FetchReady(rdy[1]), .FetchValid(fv[1]), .Data(dat[1]), .Fault(flt[1]),
    .Hold(Hold), .LoadStart(LoadStart), .LoadBase(LoadBase), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadLast(LoadLast), .LoadBusy(busy[1]), .LoadError(lerr[1])
  );

  // counts edges at which the pipeline was allowed to advance
  always @(posedge CLK) if (!Hold) act <= act + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic mon(input int i);
    exp_t e;
    int   n;
    n = (i == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      tests++;
      fails++;
      $display("FAIL spurious_valid_d%0d: got FetchValid=1 required no pending fetch", i);
      return;
    end
    e = (i == 0) ? q0[0] : q1[0];
    chk($sformatf("data_d%0d", i), dat[i], e.data);
    chk($sformatf("fault_d%0d", i), flt[i], e.fault);
    if (!Hold) begin
      chk($sformatf("latency_d%0d", i), act, e.due);
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  always @(negedge CLK) begin
    if (!Reset) begin
      for (int i = 0; i < 2; i++) if (fv[i]) mon(i);
    end
  end

  task automatic cyc(input logic req, input logic [63:0] addr, input logic hold,
                     input logic [31:0] ed, input logic ef);
    FetchReq = req;
    Address  = addr;
    Hold     = hold;
    @(posedge CLK); #1;
    if (req && !hold) begin
      q0.push_back('{ed, ef, act});
      q1.push_back('{ed, ef, act + 1});
    end
    FetchReq = 1'b0;
    Hold     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic lcyc(input logic st, input logic [63:0] base, input logic v,
                      input logic [31:0] d, input logic last);
    LoadStart = st;
    LoadBase  = base;
    LoadValid = v;
    LoadData  = d;
    LoadLast  = last;
    #1 chk("ready_during_load", rdy, 2'b00);
    @(posedge CLK); #1;
    LoadStart = 1'b0;
    LoadValid = 1'b0;
    LoadLast  = 1'b0;
  endtask

  // after the last beat: latency-1 leaves DRAIN one cycle before latency-2
  task automatic drain_chk();
    chk("busy_drain0", busy, 2'b11);
    idle(1);
    chk("busy_drain1", busy, 2'b10);
    chk("ready_drain1", rdy, 2'b01);
    idle(1);
    chk("busy_done", busy, 2'b00);
    chk("ready_done", rdy, 2'b11);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    FetchReq = 0; Hold = 0; Address = '0;
    LoadStart = 0; LoadBase = '0; LoadValid = 0; LoadData = '0; LoadLast = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", fv, 2'b00);
    chk("rst_data0", dat[0], 32'h0);
    chk("rst_data1", dat[1], 32'h0);
    chk("rst_fault", flt, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk("rst_lerr", lerr, 2'b00);
    Reset = 1'b0;
    #1 chk("ready_after_reset", rdy, 2'b11);

    // program two words at 0, then fetch back-to-back
    lcyc(1, 64'h0, 0, '0, 0);
    chk("busy_load", busy, 2'b11);
    chk("lerr_aligned", lerr, 2'b00);
    lcyc(0, '0, 1, 32'hF84003E9, 0);
    lcyc(0, '0, 1, 32'hF84083EA, 1);
    drain_chk();
    cyc(1, 64'h0, 0, 32'hF84003E9, 0);
    cyc(1, 64'h4, 0, 32'hF84083EA, 0);
    idle(3);

    // faults and range boundaries
    cyc(1, 64'h2,   0, FD, 1);
    cyc(1, 64'h100, 0, FD, 1);
    cyc(1, 64'hFC,  0, 32'h0, 0);
    cyc(1, 64'h8000_0000_0000_0000, 0, FD, 1);
    cyc(1, 64'h101, 0, FD, 1);
    idle(3);

    // hold for two cycles after the second acceptance
    cyc(1, 64'h0, 0, 32'hF84003E9, 0);
    cyc(1, 64'h4, 0, 32'hF84083EA, 0);
    cyc(0, '0, 1, '0, 0);
    cyc(1, 64'h8, 1, '0, 0);
    cyc(1, 64'h2, 0, FD, 1);
    idle(3);

    // streaming load at 0x34
    lcyc(1, 64'h34, 0, '0, 0);
    lcyc(0, '0, 1, 32'hD2E24689, 0);
    lcyc(0, '0, 1, 32'hD2CACF0A, 0);
    lcyc(0, '0, 1, 32'hAA0A0129, 0);
    lcyc(0, '0, 1, 32'hD2B3578A, 1);
    drain_chk();
    cyc(1, 64'h3C, 0, 32'hAA0A0129, 0);
    cyc(1, 64'h34, 0, 32'hD2E24689, 0);
    cyc(1, 64'h40, 0, 32'hD2B3578A, 0);
    idle(3);

    // load running off the end of the array
    lcyc(1, 64'hFC, 0, '0, 0);
    chk("lerr_start_end", lerr, 2'b00);
    lcyc(0, '0, 1, 32'h1234_5678, 0);
    chk("lerr_beat1", lerr, 2'b00);
    lcyc(0, '0, 1, 32'h9ABC_DEF0, 0);
    chk("lerr_beat2", lerr, 2'b11);
    lcyc(0, '0, 1, 32'h0BAD_F00D, 1);
    chk("lerr_sticky", lerr, 2'b11);
    drain_chk();
    cyc(1, 64'hFC, 0, 32'h1234_5678, 0);
    idle(3);

    // next LoadStart clears the error; misaligned base sets it
    lcyc(1, 64'h0, 0, '0, 0);
    chk("lerr_cleared", lerr, 2'b00);
    lcyc(0, '0, 1, 32'h1111_1111, 1);
    drain_chk();
    lcyc(1, 64'h6, 0, '0, 0);
    chk("lerr_misaligned", lerr, 2'b11);
    lcyc(0, '0, 1, 32'h2222_2222, 1);
    drain_chk();
    cyc(1, 64'h4, 0, 32'h2222_2222, 0);
    cyc(1, 64'h0, 0, 32'h1111_1111, 0);
    idle(3);

    // asynchronous reset during an in-flight fetch and a load
    cyc(1, 64'h4, 0, 32'h2222_2222, 0);
    lcyc(1, 64'h81, 0, '0, 0);
    chk("pre_rst_busy", busy, 2'b11);
    chk("pre_rst_lerr", lerr, 2'b11);
    chk("pre_rst_valid_d2", fv[1], 1'b1);
    LoadValid = 1'b1;
    LoadData  = 32'hDEAD_BEEF;
    #2 Reset = 1'b1;
    #1;
    chk("async_valid", fv, 2'b00);
    chk("async_busy", busy, 2'b00);
    chk("async_lerr", lerr, 2'b00);
    q0.delete();
    q1.delete();
    LoadValid = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b0;
    #1 chk("ready_after_midreset", rdy, 2'b11);
    cyc(1, 64'h0, 0, 32'h1111_1111, 0);
    cyc(1, 64'h80, 0, 32'h0, 0);
    idle(4);

    chk("sb_empty_d1", q0.size(), 0);
    chk("sb_empty_d2", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
